// File: rtl/encoder_3c1s_array.sv
// encoder_3c1s_array: frame-level wrapper around LANES parallel 11b->12b
// TNS encoders. A frame of N_GRP 11-bit groups is captured on accept. It is
// then fed LANES groups per beat for BEATS beats. After the encoder latency
// has drained, the frame is presented as N_GRP 12-bit code words and held
// until the consumer takes it.
//
// Ports:
//   clock     - sole clock, rising edge
//   reset_n   - asynchronous active-low reset
//   datain    - input frame, group g = datain[11g+10:11g]
//   in_valid  - frame offered
//   in_ready  - block is IDLE and can accept a frame
//   bypass    - test mode sampled with the frame: slot = {1'b0, group}
//   codeout   - coded frame, group g = codeout[12g+11:12g]
//   out_valid - codeout holds a complete frame
//   out_ready - consumer takes the frame
//   busy      - FSM is not IDLE
//   frame_cnt - number of delivered frames (wraps)
//
// TNS code used by each lane: a group with more than five ones is sent
// inverted with flag bit 11 set. Otherwise it is sent as-is with flag 0.
// This bounds the number of ones in a code word to at most six.

// Single lane: encode (or bypass) then delay by LAT register stages.
module tns_encoder_12 #(
  parameter int LAT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [10:0] din,
  input  logic        bypass,
  output logic [11:0] code
);

  function automatic logic [11:0] tns_encode(input logic [10:0] d);
    if ($countones(d) > 5) begin
      return {1'b1, ~d};
    end else begin
      return {1'b0, d};
    end
  endfunction

  logic [11:0] word;
  logic [11:0] pipe [LAT];

  // Select coded or raw word for the first pipeline stage.
  always_comb begin
    word = 12'h000;
    if (bypass) begin
      word = {1'b0, din};
    end else begin
      word = tns_encode(din);
    end
  end

  // Latency pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 12'h000;
    end else begin
      pipe[0] <= word;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign code = pipe[LAT-1];

endmodule

module encoder_3c1s_array #(
  parameter int N_GRP   = 20,
  parameter int LANES   = 4,
  parameter int ENC_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_GRP*11-1:0]  datain,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 bypass,
  output logic [N_GRP*12-1:0]  codeout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int BEATS = N_GRP / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;

  if ((N_GRP % LANES) != 0) begin : g_bad_lanes
    $error("N_GRP must be an integer multiple of LANES");
  end
  if (ENC_LAT < 1) begin : g_bad_lat
    $error("ENC_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ENC, DRAIN, HOLD} state_t;

  state_t                state, state_nxt;
  logic [N_GRP*11-1:0]   frame;
  logic                  byp;
  logic [BW-1:0]         beat;
  logic [DW-1:0]         drain;
  logic                  out_valid_q;
  logic [N_GRP*12-1:0]   code_q;
  logic [15:0]           cnt_q;
  logic [10:0]           lane_din  [LANES];
  logic [11:0]           lane_code [LANES];
  logic                  vld_pipe  [ENC_LAT];
  logic [BW-1:0]         beat_pipe [ENC_LAT];

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = ENC;
        else          state_nxt = IDLE;
      end
      ENC: begin
        if (beat == BW'(BEATS - 1)) state_nxt = DRAIN;
        else                        state_nxt = ENC;
      end
      DRAIN: begin
        if (drain == DW'(ENC_LAT - 1)) state_nxt = HOLD;
        else                           state_nxt = DRAIN;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
        else           state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and out_valid, which is high exactly while in HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == HOLD);
    end
  end

  // Frame capture at accept, plus the beat and drain counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame <= '0;
      byp   <= 1'b0;
      beat  <= '0;
      drain <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        frame <= datain;
        byp   <= bypass;
      end
      if (state == ENC && beat != BW'(BEATS - 1)) beat <= beat + 1'b1;
      else                                        beat <= '0;
      if (state == DRAIN && drain != DW'(ENC_LAT - 1)) drain <= drain + 1'b1;
      else                                             drain <= '0;
    end
  end

  // Route the current beat's groups onto the lanes.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_din[j] = frame[(int'(beat) * LANES + j) * 11 +: 11];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    tns_encoder_12 #(.LAT(ENC_LAT)) u_enc (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (lane_din[j]),
      .bypass  (byp),
      .code    (lane_code[j])
    );
  end

  // Beat index and valid travel alongside the lanes so that each lane result
  // lands in the slot it was taken from. Reset clears the valids, so results
  // still in flight are never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENC_LAT; i++) begin
        vld_pipe[i]  <= 1'b0;
        beat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= (state == ENC);
      beat_pipe[0] <= beat;
      for (int i = 1; i < ENC_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        beat_pipe[i] <= beat_pipe[i-1];
      end
    end
  end

  // Output slot write-back and delivered-frame counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code_q <= '0;
      cnt_q  <= 16'h0000;
    end else begin
      if (vld_pipe[ENC_LAT-1]) begin
        for (int j = 0; j < LANES; j++) begin
          code_q[(int'(beat_pipe[ENC_LAT-1]) * LANES + j) * 12 +: 12] <= lane_code[j];
        end
      end
      if (state == HOLD && out_ready) cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign codeout   = code_q;
  assign frame_cnt = cnt_q;

endmodule
